// File: rtl/l2_adapter_pkg.sv
// rtl/l2_adapter_pkg.sv - shared types and constants for the L2 block adapter
package l2_adapter_pkg;

  // Status code seen by the coherence bus controller
  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  // Adapter sequencing states
  typedef enum logic [2:0] {
    FSM_IDLE = 3'd0,
    FSM_RD   = 3'd1,
    FSM_WR   = 3'd2,
    FSM_DONE = 3'd3,
    FSM_ERR  = 3'd4
  } adapter_fsm_t;

  // Default geometry: 32-bit words, 2-word blocks
  localparam int WORD_W_DEFAULT           = 32;
  localparam int BLOCK_SIZE_WORDS_DEFAULT = 2;
  localparam int BYTES_PER_WORD           = WORD_W_DEFAULT / 8;
  localparam int OFFSET_BITS              = $clog2(BLOCK_SIZE_WORDS_DEFAULT) + 2;

  // Byte-address bits covered by one block (word stride is always 4 bytes)
  function automatic int offset_bits(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

endpackage

// File: rtl/l2_wait_timer.sv
// rtl/l2_wait_timer.sv - saturating wait counter that flags expiry at TIMEOUT-1
module l2_wait_timer #(
  parameter int TIMEOUT = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Clear wins; counting stops once expired so the counter can never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_block_adapter.sv
// rtl/l2_block_adapter.sv - splits one block read/write into sequential word accesses
module l2_block_adapter
  import l2_adapter_pkg::*;
#(
  parameter int BLOCK_SIZE_WORDS = 2,
  parameter int WORD_W           = 32,
  parameter int TIMEOUT          = 10000
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               blk_ren,
  input  logic                               blk_wen,
  input  logic [WORD_W-1:0]                  blk_addr,
  input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] blk_store,
  output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] blk_load,
  output logic [1:0]                         blk_state,
  output logic                               mem_ren,
  output logic                               mem_wen,
  output logic [WORD_W-1:0]                  mem_addr,
  output logic [WORD_W-1:0]                  mem_wdata,
  input  logic [WORD_W-1:0]                  mem_rdata,
  input  logic                               mem_ready,
  input  logic                               mem_error
);

  localparam int BLK_OFFSET_BITS = offset_bits(BLOCK_SIZE_WORDS);
  localparam int IDX_W           = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
  localparam int BLK_W           = BLOCK_SIZE_WORDS * WORD_W;
  localparam logic [WORD_W-1:0] OFFSET_MASK = WORD_W'((64'd1 << BLK_OFFSET_BITS) - 64'd1);

  adapter_fsm_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [BLK_W-1:0]  store_q, store_d;
  logic [BLK_W-1:0]  load_q, load_d;
  l2_state_t         blk_state_q, blk_state_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

  logic busy;
  logic busy_next;
  logic last_word;
  logic timer_expired;

  assign busy      = (state_q == FSM_RD) || (state_q == FSM_WR);
  assign busy_next = (state_d == FSM_RD) || (state_d == FSM_WR);
  assign last_word = (idx_q == IDX_W'(BLOCK_SIZE_WORDS - 1));

  // Counter runs only while a word is outstanding; any completion restarts it
  l2_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (!busy || mem_ready || mem_error),
    .enable  (busy),
    .expired (timer_expired)
  );

  // Next state, datapath, and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    store_d     = store_q;
    load_d      = load_q;
    blk_state_d = L2_FREE;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      FSM_IDLE: begin
        if (blk_ren && blk_wen) begin
          state_d = FSM_ERR;
        end else if (blk_ren || blk_wen) begin
          base_d = blk_addr & ~OFFSET_MASK;
          idx_d  = '0;
          if (blk_wen) begin
            store_d = blk_store;
            state_d = FSM_WR;
          end else begin
            state_d = FSM_RD;
          end
        end
      end
      FSM_RD, FSM_WR: begin
        if (mem_error) begin
          state_d = FSM_ERR;
        end else if (mem_ready) begin
          if (state_q == FSM_RD) begin
            for (int i = 0; i < BLOCK_SIZE_WORDS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                load_d[i*WORD_W +: WORD_W] = mem_rdata;
              end
            end
          end
          if (last_word) begin
            idx_d   = '0;
            state_d = FSM_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timer_expired) begin
          state_d = FSM_ERR;
        end
      end
      default: begin
        state_d = FSM_IDLE;
      end
    endcase

    case (state_d)
      FSM_RD, FSM_WR: blk_state_d = L2_BUSY;
      FSM_DONE:       blk_state_d = L2_ACCESS;
      FSM_ERR:        blk_state_d = L2_ERROR;
      default:        blk_state_d = L2_FREE;
    endcase

    mem_ren_d = (state_d == FSM_RD);
    mem_wen_d = (state_d == FSM_WR);
    if (busy_next) begin
      mem_addr_d = base_d + (WORD_W'(idx_d) << 2);
    end
    if (state_d == FSM_WR) begin
      for (int i = 0; i < BLOCK_SIZE_WORDS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          mem_wdata_d = store_d[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Single state/output register bank
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FSM_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      store_q     <= '0;
      load_q      <= '0;
      blk_state_q <= L2_FREE;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      store_q     <= store_d;
      load_q      <= load_d;
      blk_state_q <= blk_state_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign blk_load  = load_q;
  assign blk_state = blk_state_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_l2_block_adapter.sv
// tb/tb_l2_block_adapter.sv - directed self-checking bench for l2_block_adapter
module tb_l2_block_adapter;

  logic        clk;
  logic        rst;

  logic        a_ren, a_wen;
  logic [31:0] a_addr;
  logic [63:0] a_store;
  logic [63:0] a_load;
  logic [1:0]  a_state;
  logic        a_mren, a_mwen;
  logic [31:0] a_maddr, a_mwdata, a_mrdata;
  logic        a_ready, a_error;

  logic         b_ren, b_wen;
  logic [31:0]  b_addr;
  logic [127:0] b_store;
  logic [127:0] b_load;
  logic [1:0]   b_state;
  logic         b_mren, b_mwen;
  logic [31:0]  b_maddr, b_mwdata, b_mrdata;
  logic         b_ready, b_error;

  int n_checks;
  int n_errors;

  assign a_mrdata = {16'hD00D, a_maddr[15:0]};
  assign b_mrdata = {16'hB0B0, b_maddr[15:0]};

  l2_block_adapter #(.BLOCK_SIZE_WORDS(2), .WORD_W(32), .TIMEOUT(8)) dut_a (
    .CLK(clk), .RST(rst), .blk_ren(a_ren), .blk_wen(a_wen), .blk_addr(a_addr),
    .blk_store(a_store), .blk_load(a_load), .blk_state(a_state),
    .mem_ren(a_mren), .mem_wen(a_mwen), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata), .mem_ready(a_ready), .mem_error(a_error)
  );

  l2_block_adapter #(.BLOCK_SIZE_WORDS(4), .WORD_W(32), .TIMEOUT(8)) dut_b (
    .CLK(clk), .RST(rst), .blk_ren(b_ren), .blk_wen(b_wen), .blk_addr(b_addr),
    .blk_store(b_store), .blk_load(b_load), .blk_state(b_state),
    .mem_ren(b_mren), .mem_wen(b_mwen), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata), .mem_ready(b_ready), .mem_error(b_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a_ren = 0; a_wen = 0; a_addr = '0; a_store = '0; a_ready = 0; a_error = 0;
    b_ren = 0; b_wen = 0; b_addr = '0; b_store = '0; b_ready = 1; b_error = 0;
    tick(); tick();

    // Reset state
    check("rst_state", a_state, 2'd0);
    check("rst_load",  a_load, 64'h0);
    check("rst_ren",   a_mren, 1'b0);
    check("rst_wen",   a_mwen, 1'b0);
    check("rst_addr",  a_maddr, 32'h0);
    check("rst_wdata", a_mwdata, 32'h0);
    rst = 1'b0;
    tick();

    // T1: read, ready tied high, unaligned request address
    a_ready = 1; a_ren = 1; a_addr = 32'h0000_1004;
    tick();
    a_ren = 0;
    check("t1_busy0",  a_state, 2'd1);
    check("t1_ren0",   a_mren, 1'b1);
    check("t1_addr0",  a_maddr, 32'h0000_1000);
    tick();
    check("t1_addr1",  a_maddr, 32'h0000_1004);
    check("t1_busy1",  a_state, 2'd1);
    tick();
    check("t1_access", a_state, 2'd2);
    check("t1_ren_lo", a_mren, 1'b0);
    check("t1_load",   a_load, 64'hD00D1004_D00D1000);
    tick();
    check("t1_free",   a_state, 2'd0);

    // T2: write, each word ready on its third cycle
    a_ready = 0; a_wen = 1; a_addr = 32'h0000_2000; a_store = 64'hBEEF0001_CAFE0000;
    tick();
    a_wen = 0;
    check("t2_wen0",   a_mwen, 1'b1);
    check("t2_addr0",  a_maddr, 32'h0000_2000);
    check("t2_wdata0", a_mwdata, 32'hCAFE0000);
    tick(); tick();
    check("t2_hold_addr0",  a_maddr, 32'h0000_2000);
    check("t2_hold_wdata0", a_mwdata, 32'hCAFE0000);
    check("t2_hold_wen0",   a_mwen, 1'b1);
    check("t2_hold_busy0",  a_state, 2'd1);
    a_ready = 1;
    tick();
    a_ready = 0;
    check("t2_addr1",  a_maddr, 32'h0000_2004);
    check("t2_wdata1", a_mwdata, 32'hBEEF0001);
    tick(); tick();
    check("t2_hold_busy1",  a_state, 2'd1);
    check("t2_hold_wdata1", a_mwdata, 32'hBEEF0001);
    a_ready = 1;
    tick();
    a_ready = 0;
    check("t2_access", a_state, 2'd2);
    check("t2_wen_lo", a_mwen, 1'b0);
    tick();
    check("t2_free",   a_state, 2'd0);

    // T3: read, error on word 1 while ready is also high
    a_ready = 1; a_ren = 1; a_addr = 32'h0000_3000;
    tick();
    a_ren = 0;
    tick();
    check("t3_addr1",  a_maddr, 32'h0000_3004);
    a_error = 1;
    tick();
    a_error = 0;
    check("t3_error",  a_state, 2'd3);
    check("t3_ren_lo", a_mren, 1'b0);
    check("t3_load",   a_load, 64'hD00D1004_D00D3000);
    tick();
    check("t3_free",   a_state, 2'd0);

    // T4: ready never arrives, TIMEOUT=8
    a_ready = 0; a_ren = 1; a_addr = 32'h0000_4000;
    tick();
    a_ren = 0;
    check("t4_strobe", a_mren, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("t4_busy_%0d", i), a_state, 2'd1);
    end
    tick();
    check("t4_error",  a_state, 2'd3);
    check("t4_ren_lo", a_mren, 1'b0);
    tick();
    check("t4_free",   a_state, 2'd0);

    // T5: simultaneous read and write request
    a_ren = 1; a_wen = 1; a_addr = 32'h0000_5000;
    tick();
    a_ren = 0; a_wen = 0;
    check("t5_error",  a_state, 2'd3);
    check("t5_ren",    a_mren, 1'b0);
    check("t5_wen",    a_mwen, 1'b0);
    tick();
    check("t5_free",   a_state, 2'd0);
    check("t5_wen2",   a_mwen, 1'b0);

    // T6: reset while the second write word is outstanding, then a fresh read
    a_ready = 0; a_wen = 1; a_addr = 32'h0000_5000; a_store = 64'h11111111_22222222;
    tick();
    a_wen = 0;
    a_ready = 1;
    tick();
    a_ready = 0;
    check("t6_wen1",   a_mwen, 1'b1);
    check("t6_addr1",  a_maddr, 32'h0000_5004);
    rst = 1;
    tick();
    rst = 0;
    check("t6_free",   a_state, 2'd0);
    check("t6_wen_lo", a_mwen, 1'b0);
    check("t6_addr",   a_maddr, 32'h0);
    check("t6_wdata",  a_mwdata, 32'h0);
    check("t6_load",   a_load, 64'h0);
    a_ready = 1; a_ren = 1; a_addr = 32'h0000_6008;
    tick();
    a_ren = 0;
    check("t6_raddr0", a_maddr, 32'h0000_6008);
    tick();
    tick();
    check("t6_access", a_state, 2'd2);
    check("t6_rload",  a_load, 64'hD00D600C_D00D6008);

    // Top-of-memory block with 4-word blocks: offset bits [3:0] are cleared
    b_ren = 1; b_addr = 32'hFFFF_FFF8;
    tick();
    b_ren = 0;
    check("tx_addr0", b_maddr, 32'hFFFF_FFF0);
    tick();
    check("tx_addr1", b_maddr, 32'hFFFF_FFF4);
    tick();
    check("tx_addr2", b_maddr, 32'hFFFF_FFF8);
    tick();
    check("tx_addr3", b_maddr, 32'hFFFF_FFFC);
    tick();
    check("tx_access", b_state, 2'd2);
    check("tx_load",   b_load, 128'hB0B0FFFC_B0B0FFF8_B0B0FFF4_B0B0FFF0);
    tick();
    check("tx_free",   b_state, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
